// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART driver: FSM states, register
// addresses and the baud divisor table.
package spart_pkg;

  typedef enum logic [2:0] {
    StInit,
    StCfgLo,
    StCfgHi,
    StIdle,
    StWaitTbr,
    StWriteTx
  } state_e;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // Index 0 is the rightmost element: br_cfg 00 -> 650 ... 11 -> 80.
  localparam logic [3:0][15:0] DIV = {16'd80, 16'd162, 16'd325, 16'd650};

endpackage

// File: rtl/spart_driver_if.sv
// Control/handshake signals between the echo driver and the SPART.
interface spart_driver_if;

  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    input  rda,
    input  tbr
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    output rda,
    output tbr
  );

endinterface

// File: rtl/spart_driver.sv
// Programs the SPART baud divisor, then echoes every received byte back out,
// counting echoes and flagging bytes dropped while busy.
module spart_driver
  import spart_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus,
  output logic [7:0]     echo_cnt,
  output logic           overrun
);

  state_e     state_q, state_d;
  logic [1:0] br_q;
  logic [1:0] cfg_q, cfg_d;
  logic [7:0] echo_q, echo_d;
  logic [7:0] cnt_q;
  logic       ovr_q;

  logic       iocs, iorw;
  logic [1:0] ioaddr;
  logic [7:0] dout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      br_q   <= br_cfg;
      cfg_q  <= br_cfg;
      echo_q <= 8'h00;
      cnt_q  <= 8'h00;
      ovr_q  <= 1'b0;
    end else begin
      br_q   <= br_cfg;
      cfg_q  <= cfg_d;
      echo_q <= echo_d;
      if (state_q == StWriteTx) begin
        cnt_q <= cnt_q + 8'd1;
      end
      // A byte arriving outside IDLE cannot be read and is lost.
      if (bus.rda && (state_q != StIdle)) begin
        ovr_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    echo_d  = echo_q;
    unique case (state_q)
      StInit: begin
        state_d = StCfgLo;
        cfg_d   = br_q;
      end
      StCfgLo: state_d = StCfgHi;
      StCfgHi: state_d = StIdle;
      StIdle: begin
        if (bus.rda) begin
          echo_d  = databus;
          state_d = StWaitTbr;
        end else if (br_q != cfg_q) begin
          state_d = StCfgLo;
          cfg_d   = br_q;
        end
      end
      StWaitTbr: begin
        if (bus.tbr) begin
          state_d = StWriteTx;
        end
      end
      StWriteTx: state_d = StIdle;
      default:   state_d = StInit;
    endcase
  end

  always_comb begin
    iocs   = 1'b0;
    iorw   = 1'b1;
    ioaddr = ADDR_BUF;
    dout   = 8'h00;
    unique case (state_q)
      StInit: ;
      StCfgLo: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = ADDR_DBL;
        dout   = DIV[cfg_q][7:0];
      end
      StCfgHi: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = ADDR_DBH;
        dout   = DIV[cfg_q][15:8];
      end
      StIdle: iocs = 1'b1;
      StWaitTbr: ;
      StWriteTx: begin
        iocs = 1'b1;
        iorw = 1'b0;
        dout = echo_q;
      end
      default: ;
    endcase
  end

  assign bus.iocs   = iocs;
  assign bus.iorw   = iorw;
  assign bus.ioaddr = ioaddr;
  assign databus    = (iocs && !iorw) ? dout : 8'hzz;
  assign echo_cnt   = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_spart_driver;

  localparam int PH_INIT  = 0;
  localparam int PH_CFGLO = 1;
  localparam int PH_CFGHI = 2;
  localparam int PH_IDLE  = 3;
  localparam int PH_WAIT  = 4;
  localparam int PH_WRITE = 5;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic [7:0] spart_data;
  logic [7:0] echo_cnt;
  logic       overrun;
  wire  [7:0] databus;

  spart_driver_if bus_if ();

  spart_driver dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .bus      (bus_if.master),
    .databus  (databus),
    .echo_cnt (echo_cnt),
    .overrun  (overrun)
  );

  // SPART side: answers reads of the rx buffer.
  assign databus = (bus_if.iocs && bus_if.iorw) ? spart_data : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference model.
  int div_tab [4] = '{650, 325, 162, 80};
  int m_phase;
  int m_br, m_cfg, m_echo, m_cnt;
  bit m_ovr;

  always @(posedge clk) begin
    if (!rst) begin
      m_phase <= PH_INIT;
      m_br    <= int'(br_cfg);
      m_cfg   <= int'(br_cfg);
      m_echo  <= 0;
      m_cnt   <= 0;
      m_ovr   <= 1'b0;
    end else begin
      m_br <= int'(br_cfg);
      if (bus_if.rda && m_phase != PH_IDLE) m_ovr <= 1'b1;
      case (m_phase)
        PH_INIT: begin
          m_phase <= PH_CFGLO;
          m_cfg   <= m_br;
        end
        PH_CFGLO: m_phase <= PH_CFGHI;
        PH_CFGHI: m_phase <= PH_IDLE;
        PH_IDLE: begin
          if (bus_if.rda) begin
            m_echo  <= int'(spart_data);
            m_phase <= PH_WAIT;
          end else if (m_br != m_cfg) begin
            m_cfg   <= m_br;
            m_phase <= PH_CFGLO;
          end
        end
        PH_WAIT: if (bus_if.tbr) m_phase <= PH_WRITE;
        PH_WRITE: begin
          m_cnt   <= (m_cnt + 1) % 256;
          m_phase <= PH_IDLE;
        end
        default: m_phase <= PH_INIT;
      endcase
    end
  end

  function automatic int exp_iocs(input int ph);
    return (ph == PH_INIT || ph == PH_WAIT) ? 0 : 1;
  endfunction

  function automatic int exp_iorw(input int ph);
    return (ph == PH_CFGLO || ph == PH_CFGHI || ph == PH_WRITE) ? 0 : 1;
  endfunction

  function automatic int exp_addr(input int ph);
    if (ph == PH_CFGLO) return 2;
    if (ph == PH_CFGHI) return 3;
    return 0;
  endfunction

  function automatic int exp_data(input int ph);
    if (ph == PH_CFGLO) return div_tab[m_cfg] % 256;
    if (ph == PH_CFGHI) return div_tab[m_cfg] / 256;
    return m_echo;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("iocs", int'(bus_if.iocs), exp_iocs(m_phase));
      chk("iorw", int'(bus_if.iorw), exp_iorw(m_phase));
      if (m_phase != PH_WAIT) chk("ioaddr", int'(bus_if.ioaddr), exp_addr(m_phase));
      if (exp_iorw(m_phase) == 0) chk("databus", int'(databus), exp_data(m_phase));
      chk("echo_cnt", int'(echo_cnt), m_cnt);
      chk("overrun", int'(overrun), int'(m_ovr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_iocs"}, int'(bus_if.iocs), 1);
    chk({name, "_iorw"}, int'(bus_if.iorw), 1);
    chk({name, "_addr"}, int'(bus_if.ioaddr), 0);
  endtask

  initial begin
    int  waited;
    bit  found;
    rst        = 1'b0;
    br_cfg     = 2'b01;
    spart_data = 8'h00;
    bus_if.rda = 1'b0;
    bus_if.tbr = 1'b0;

    // Reset and divisor programming at 9600.
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b1;
    sample();
    chk("init_iocs", int'(bus_if.iocs), 0);
    step(); sample();
    chk("cfglo_addr", int'(bus_if.ioaddr), 2);
    chk("cfglo_data", int'(databus), 8'h45);
    step(); sample();
    chk("cfghi_addr", int'(bus_if.ioaddr), 3);
    chk("cfghi_data", int'(databus), 8'h01);
    step(); sample();
    chk_idle("first_idle");

    // Minimum-latency echo.
    step();
    bus_if.rda = 1'b1; spart_data = 8'hA5; bus_if.tbr = 1'b1;
    step();
    bus_if.rda = 1'b0;
    sample();
    chk("wait_iocs", int'(bus_if.iocs), 0);
    step(); sample();
    chk("echo_data", int'(databus), 8'hA5);
    chk("echo_iorw", int'(bus_if.iorw), 0);
    chk("echo_cnt_pre", int'(echo_cnt), 0);
    step(); sample();
    chk("echo_cnt_post", int'(echo_cnt), 1);

    // Stalled tbr with a second byte arriving.
    step();
    bus_if.rda = 1'b1; spart_data = 8'h3C; bus_if.tbr = 1'b0;
    step();
    bus_if.rda = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      chk("stall_iocs", int'(bus_if.iocs), 0);
      step();
      bus_if.rda = (i == 5);
      spart_data = 8'h77;
    end
    bus_if.rda = 1'b0;
    bus_if.tbr = 1'b1;
    step(); sample();
    chk("stall_echo_data", int'(databus), 8'h3C);
    chk("stall_overrun", int'(overrun), 1);
    step(); sample();
    chk("stall_cnt", int'(echo_cnt), 2);

    // Reconfiguration from IDLE to 38400.
    step();
    br_cfg = 2'b11;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 6) begin
      sample();
      if (bus_if.iocs && !bus_if.iorw && bus_if.ioaddr == 2'b10) found = 1'b1;
      else step();
      waited++;
    end
    chk("recfg_found", int'(found), 1);
    chk("recfg_lo", int'(databus), 8'h50);
    step(); sample();
    chk("recfg_hi_addr", int'(bus_if.ioaddr), 3);
    chk("recfg_hi", int'(databus), 8'h00);
    step(); sample();
    chk_idle("recfg_idle");

    // Baud change while waiting for tbr is deferred until after the echo.
    step();
    bus_if.rda = 1'b1; spart_data = 8'hC3; bus_if.tbr = 1'b0;
    step();
    bus_if.rda = 1'b0;
    br_cfg = 2'b00;
    step(); step(); step();
    bus_if.tbr = 1'b1;
    step(); sample();
    chk("defer_echo", int'(databus), 8'hC3);
    chk("defer_iorw", int'(bus_if.iorw), 0);
    step(); sample();
    chk_idle("defer_idle");
    step(); sample();
    chk("defer_lo_addr", int'(bus_if.ioaddr), 2);
    chk("defer_lo", int'(databus), 8'h8A);
    step(); sample();
    chk("defer_hi", int'(databus), 8'h02);
    step(); sample();
    chk_idle("defer_idle2");

    // 256 echoes from a fresh reset wrap the counter.
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step(); step(); step();
    for (int i = 0; i < 256; i++) begin
      bus_if.rda = 1'b1;
      spart_data = 8'($urandom);
      step();
      bus_if.rda = 1'b0;
      step(); step();
      if (i == 254) begin
        sample();
        chk("cnt_255", int'(echo_cnt), 255);
      end
    end
    sample();
    chk("cnt_wrap", int'(echo_cnt), 0);

    // Reset landing in WRITE_TX, with overrun set beforehand.
    bus_if.rda = 1'b1;
    step();
    step();
    bus_if.rda = 1'b0;
    sample();
    chk("prerst_overrun", int'(overrun), 1);
    chk("prerst_iorw", int'(bus_if.iorw), 0);
    rst = 1'b0;
    step(); sample();
    chk("rst_iocs", int'(bus_if.iocs), 0);
    chk("rst_cnt", int'(echo_cnt), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step();
      rst        = ($urandom_range(0, 299) != 0);
      bus_if.rda = ($urandom_range(0, 5) == 0);
      spart_data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus_if.tbr = ~bus_if.tbr;
      if ($urandom_range(0, 49) == 0) br_cfg = 2'($urandom);
    end
    sample();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
